// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants and hex segment table for the seven-segment scanner
package seven_seg_pkg;

    localparam int SEG_WIDTH = 7;

    // Bit positions within a {g,f,e,d,c,b,a} segment word
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high segment patterns, entry 15 (F) first so index n selects hex digit n
    localparam logic [15:0][SEG_WIDTH-1:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [SEG_WIDTH-1:0] hex_to_seg(input logic [3:0] value);
        return HEX_SEG_TABLE[value];
    endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// rtl/seven_segment_decoder.sv - combinational hex digit to active-high segment decoder with blank
module seven_segment_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0]           value,
    input  logic                 blank,
    output logic [SEG_WIDTH-1:0] segments
);

    // A blanked digit lights nothing; otherwise look up the hex pattern
    always_comb begin
        segments = '0;
        if (!blank) begin
            segments = hex_to_seg(value);
        end
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - frame-snapshot, time-multiplexed common-anode display scanner
module seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS          = 4,
    parameter int REFRESH_DIV         = 100000,
    parameter int GUARD_CYCLES        = 100,
    parameter int ANODE_ACTIVE_LOW    = 1,
    parameter int SEG_ACTIVE_LOW      = 1,
    parameter int BLANK_LEADING_ZEROS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   anode_out,
    output logic [SEG_WIDTH-1:0]    segment_out,
    output logic                    dp_out,
    output logic                    frame_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_VAL = PW'(GUARD_CYCLES);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    // Inactive levels of the physical pins
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [SEG_WIDTH-1:0]  SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic                  DP_OFF    = (SEG_ACTIVE_LOW != 0);

    logic [PW-1:0]                 prescaler_q, prescaler_d;
    logic [IW-1:0]                 index_q, index_d;
    logic [NUM_DIGITS-1:0][3:0]    snap_digits_q, snap_digits_d;
    logic [NUM_DIGITS-1:0]         snap_dp_q, snap_dp_d;
    logic                          primed_q, primed_d;
    logic                          frame_tick_q, frame_tick_d;
    logic [NUM_DIGITS-1:0]         anode_q, anode_d;
    logic [SEG_WIDTH-1:0]          seg_q, seg_d;
    logic                          dp_q, dp_d;

    logic                          snap_load;
    logic [NUM_DIGITS-1:0]         blank_mask;
    logic [SEG_WIDTH-1:0]          seg_raw;

    // Slot timing and frame snapshot: counters advance only while enabled,
    // and the snapshot is taken on priming or when the last slot wraps
    always_comb begin
        logic pre_wrap;
        logic idx_wrap;
        pre_wrap      = (prescaler_q == PRE_MAX);
        idx_wrap      = pre_wrap && (index_q == IDX_MAX);
        snap_load     = enable && (!primed_q || idx_wrap);
        prescaler_d   = prescaler_q;
        index_d       = index_q;
        snap_digits_d = snap_digits_q;
        snap_dp_d     = snap_dp_q;
        primed_d      = primed_q | enable;
        frame_tick_d  = snap_load;
        if (enable) begin
            prescaler_d = pre_wrap ? '0 : prescaler_q + 1'b1;
            if (pre_wrap) begin
                index_d = idx_wrap ? '0 : index_q + 1'b1;
            end
        end
        if (snap_load) begin
            snap_digits_d = digits_in;
            snap_dp_d     = dp_in;
        end
    end

    // Leading-zero mask: a digit blanks when it and everything above it is zero with no dp
    always_comb begin
        logic zero_run;
        zero_run   = 1'b1;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run && (snap_digits_q[i] == 4'd0) && !snap_dp_q[i];
            blank_mask[i] = (BLANK_LEADING_ZEROS != 0) && (i > 0) && zero_run;
        end
    end

    seven_segment_decoder u_decoder (
        .value    (snap_digits_q[index_q]),
        .blank    (blank_mask[index_q]),
        .segments (seg_raw)
    );

    // Drive pins for the current slot, dark during the guard window or while disabled
    always_comb begin
        logic show;
        show    = enable && (prescaler_q >= GUARD_VAL);
        anode_d = ANODE_OFF;
        seg_d   = SEG_OFF;
        dp_d    = DP_OFF;
        if (show) begin
            anode_d[index_q] = ~ANODE_OFF[0];
            seg_d            = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
            dp_d             = (snap_dp_q[index_q] && !blank_mask[index_q]) ^ DP_OFF;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler_q   <= '0;
            index_q       <= '0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            primed_q      <= 1'b0;
            frame_tick_q  <= 1'b0;
            anode_q       <= ANODE_OFF;
            seg_q         <= SEG_OFF;
            dp_q          <= DP_OFF;
        end else begin
            prescaler_q   <= prescaler_d;
            index_q       <= index_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            primed_q      <= primed_d;
            frame_tick_q  <= frame_tick_d;
            anode_q       <= anode_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign anode_out   = anode_q;
    assign segment_out = seg_q;
    assign dp_out      = dp_q;
    assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - self-checking bench for seven_segment_scanner
module tb_seven_segment_scanner;

    localparam int N = 4;
    localparam int R = 8;
    localparam int G = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  anode_out;
    logic [6:0]  segment_out;
    logic        dp_out;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    int          m_pos;
    bit          m_primed;
    logic [15:0] m_snap;
    logic [3:0]  m_sdp;
    logic [6:0]  hex_tab [16];

    seven_segment_scanner #(
        .NUM_DIGITS          (N),
        .REFRESH_DIV         (R),
        .GUARD_CYCLES        (G),
        .ANODE_ACTIVE_LOW    (1),
        .SEG_ACTIVE_LOW      (1),
        .BLANK_LEADING_ZEROS (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .anode_out   (anode_out),
        .segment_out (segment_out),
        .dp_out      (dp_out),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos    = 0;
        m_primed = 0;
        m_snap   = '0;
        m_sdp    = '0;
    endtask

    // One clock: predict registered outputs from the time-in-frame position, advance, compare
    task automatic tick();
        int         p;
        int         idx;
        bit         blank_i;
        logic [3:0] e_anode;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_tick;
        e_anode = 4'hF;
        e_seg   = 7'h7F;
        e_dp    = 1'b1;
        e_tick  = 1'b0;
        if (enable) begin
            p   = m_pos % R;
            idx = (m_pos / R) % N;
            if (p >= G) begin
                blank_i = (idx > 0) && ((m_snap >> (4 * idx)) == 16'd0) && ((m_sdp >> idx) == 4'd0);
                e_anode = ~(4'b0001 << idx);
                e_seg   = blank_i ? 7'h7F : ~hex_tab[m_snap[4*idx +: 4]];
                e_dp    = !(m_sdp[idx] && !blank_i);
            end
            e_tick = !m_primed || ((m_pos % (R * N)) == R * N - 1);
            if (e_tick) begin
                m_snap = digits_in;
                m_sdp  = dp_in;
            end
            m_primed = 1;
            m_pos    = (m_pos + 1) % (R * N);
        end
        @(posedge clk);
        #1;
        chk("anode", anode_out, e_anode);
        chk("seg", segment_out, e_seg);
        chk("dp", dp_out, e_dp);
        chk("frame_tick", frame_tick, e_tick);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [15:0] mask;
        hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        rst       = 1'b0;
        enable    = 1'b0;
        digits_in = '0;
        dp_in     = '0;
        model_reset();

        // Reset state
        #22;
        chk("rst_anode", anode_out, 4'hF);
        chk("rst_seg", segment_out, 7'h7F);
        chk("rst_dp", dp_out, 1'b1);
        chk("rst_tick", frame_tick, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run(3);

        // Basic scan of 1234
        enable    = 1'b1;
        digits_in = 16'h1234;
        tick();
        chk("prime_tick", frame_tick, 1'b1);
        tick();
        chk("slot0_anode", anode_out, 4'b1110);
        chk("slot0_seg", segment_out, 7'h19);
        run(40);

        // Anti-tearing: change inputs mid-frame
        digits_in = 16'h9999;
        run(40);

        // Leading-zero blanking, then a dp on the top digit
        digits_in = 16'h0050;
        run(40);
        dp_in = 4'b1000;
        run(40);
        dp_in = 4'b0000;

        // Freeze at prescaler 3 of slot 2
        digits_in = 16'h8a3c;
        for (int i = 0; i < 64 && m_pos != 2 * R + 3; i++) tick();
        chk("freeze_reached", m_pos, 2 * R + 3);
        enable = 1'b0;
        run(3);
        enable = 1'b1;
        run(40);

        // Reset mid-slot 1
        for (int i = 0; i < 64 && m_pos != R + 4; i++) tick();
        chk("midrst_reached", m_pos, R + 4);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_anode", anode_out, 4'hF);
        chk("midrst_seg", segment_out, 7'h7F);
        chk("midrst_dp", dp_out, 1'b1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        digits_in = 16'h4321;
        run(40);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 3))
                0:       mask = 16'hFFFF;
                1:       mask = 16'h00FF;
                2:       mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            digits_in = 16'($urandom) & mask;
            dp_in     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
